// File: rtl/imm_ext_pipe.sv
//------------------------------------------------------------------------------
// Module      : imm_ext_pipe
// Description : RISC-V immediate extraction stage with a two-entry
//               (main + skid) valid/ready output buffer. in_ready comes
//               straight from the skid valid flop, so there is no
//               combinational path from out_ready to in_ready.
//               Optional macro IMM_ILLEGAL_CHK_EN adds an out_illegal flag
//               that travels with each entry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_ext_pipe #(
  parameter int              XLEN    = 32,   // 32 or 64 only
  parameter logic [XLEN-1:0] RST_IMM = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext
`ifdef IMM_ILLEGAL_CHK_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [2:0] C_SRC_I     = 3'b000;
  localparam logic [2:0] C_SRC_S     = 3'b001;
  localparam logic [2:0] C_SRC_B     = 3'b010;
  localparam logic [2:0] C_SRC_J     = 3'b011;
  localparam logic [2:0] C_SRC_U     = 3'b100;
  localparam logic [2:0] C_SRC_SHAMT = 3'b101;
  localparam logic [2:0] C_SRC_CSR   = 3'b110;

  logic            r_main_valid;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_main_data;
  logic [XLEN-1:0] r_skid_data;
  logic [XLEN-1:0] w_imm;
  logic            w_accept;
  logic            w_drain;

`ifdef IMM_ILLEGAL_CHK_EN
  logic r_main_ill;
  logic r_skid_ill;
  logic w_illegal;

  // Reserved format, or a 32-bit shift amount with bit 5 set, is illegal
  assign w_illegal = (imm_src == 3'b111) ||
                     ((imm_src == C_SRC_SHAMT) && (XLEN == 32) && instr[25]);
  assign out_illegal = r_main_ill;
`endif

  // Flush has priority in the sequential block, so accept ignores it here
  assign w_accept  = in_valid && !r_skid_valid;
  assign w_drain   = r_main_valid && out_ready;
  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign imm_ext   = r_main_data;

  // Immediate decode; signed size casts perform the sign extension to XLEN
  always_comb begin
    w_imm = '0;
    case (imm_src)
      C_SRC_I: w_imm = XLEN'($signed(instr[31:20]));
      C_SRC_S: w_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      C_SRC_B: w_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                      instr[11:8], 1'b0}));
      C_SRC_J: w_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                      instr[30:21], 1'b0}));
      C_SRC_U: w_imm = XLEN'($signed({instr[31:12], 12'h000}));
      C_SRC_SHAMT: begin
        if (XLEN == 64) w_imm = XLEN'(instr[25:20]);
        else            w_imm = XLEN'(instr[24:20]);
      end
      C_SRC_CSR: w_imm = XLEN'(instr[19:15]);
      default:   w_imm = '0;
    endcase
  end

  // Main/skid buffer: skid refills main first; otherwise a new entry goes to
  // main when it is free or draining, else parks in skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= RST_IMM;
      r_skid_data  <= '0;
`ifdef IMM_ILLEGAL_CHK_EN
      r_main_ill   <= 1'b0;
      r_skid_ill   <= 1'b0;
`endif
    end else if (flush) begin
      // Only valid state is cleared; data registers keep their contents
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
`ifdef IMM_ILLEGAL_CHK_EN
      r_main_ill   <= 1'b0;
      r_skid_ill   <= 1'b0;
`endif
    end else if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
`ifdef IMM_ILLEGAL_CHK_EN
        r_main_ill   <= r_skid_ill;
`endif
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_imm;
`ifdef IMM_ILLEGAL_CHK_EN
        r_main_ill   <= w_illegal;
`endif
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_imm;
`ifdef IMM_ILLEGAL_CHK_EN
      r_skid_ill   <= w_illegal;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_imm_ext_pipe
// Description : Bench for imm_ext_pipe. Drives a 32-bit and a 64-bit instance
//               from the same inputs and compares both against a queue-based
//               reference model. Honours IMM_ILLEGAL_CHK_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imm_ext_pipe;

  localparam logic [31:0] RST32 = 32'hA5A5_0001;
  localparam logic [63:0] RST64 = 64'hDEAD_BEEF_0123_4567;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
`ifdef IMM_ILLEGAL_CHK_EN
  logic        ill32, ill64;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] v32;
    logic [63:0] v64;
    logic        ill32;
    logic        ill64;
  } ent_t;

  ent_t        q[$];
  logic [31:0] e32;
  logic [63:0] e64;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .RST_IMM(RST32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .instr(instr), .imm_src(imm_src),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_ext(imm32)
`ifdef IMM_ILLEGAL_CHK_EN
    , .out_illegal(ill32)
`endif
  );

  imm_ext_pipe #(.XLEN(64), .RST_IMM(RST64)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .instr(instr), .imm_src(imm_src),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm64)
`ifdef IMM_ILLEGAL_CHK_EN
    , .out_illegal(ill64)
`endif
  );

  // Immediate value as a plain signed integer, then truncated per width
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [2:0] src);
    ent_t   e;
    longint v;
    v = 0;
    e.ill32 = 1'b0;
    e.ill64 = 1'b0;
    case (src)
      3'd0: v = longint'($signed(ins[31:20]));
      3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'd4: v = longint'($signed({ins[31:12], 12'h000}));
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    e.v64 = v;
    e.v32 = v[31:0];
    if (src == 3'd5) begin
      e.v32   = {27'd0, ins[24:20]};
      e.v64   = {58'd0, ins[25:20]};
      e.ill32 = ins[25];
    end
    if (src == 3'd7) begin
      e.ill32 = 1'b1;
      e.ill64 = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready32",  64'(in_ready32),  64'(q.size() < 2));
    chk("in_ready64",  64'(in_ready64),  64'(q.size() < 2));
    chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    chk("imm32", 64'(imm32), 64'(e32));
    chk("imm64", imm64, e64);
`ifdef IMM_ILLEGAL_CHK_EN
    if (q.size() > 0) begin
      chk("ill32", 64'(ill32), 64'(q[0].ill32));
      chk("ill64", 64'(ill64), 64'(q[0].ill64));
    end
`endif
  endtask

  // One clock: update the model with the inputs seen at the edge, then check
  task automatic step();
    bit acc, drn;
    @(posedge clk);
    if (rst) begin
      q.delete();
      e32 = RST32;
      e64 = RST64;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(instr, imm_src));
    end
    if (q.size() > 0) begin
      e32 = q[0].v32;
      e64 = q[0].v64;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; imm_src = '0;
    e32 = RST32; e64 = RST64;
    #1;
    check_outputs();
    step();
    step();
    rst = 1'b0;

    // I-type all-ones immediate, single beat
    in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'b000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("i_type_imm32", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
    chk("i_type_valid", 64'(out_valid32), 64'd1);
    step();

    // U and J on the 64-bit instance
    in_valid = 1'b1; instr = 32'h800000B7; imm_src = 3'b100;
    step();
    chk("u_type_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    instr = 32'h8000006F; imm_src = 3'b011;
    step();
    chk("j_type_imm64", imm64, 64'hFFFF_FFFF_FFF0_0000);
    in_valid = 1'b0;
    step();

    // 32-bit shift amount with bit 25 set
    in_valid = 1'b1; instr = 32'h02009093; imm_src = 3'b101;
    step();
    chk("shamt_imm32", 64'(imm32), 64'd0);
    chk("shamt_imm64", imm64, 64'h20);
    in_valid = 1'b0;
    step();

    // Backpressure: three back-to-back beats, only two fit
    out_ready = 1'b0; in_valid = 1'b1;
    instr = $urandom; imm_src = 3'($urandom_range(0, 6));
    step();
    instr = $urandom; imm_src = 3'($urandom_range(0, 6));
    step();
    chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
    instr = $urandom; imm_src = 3'($urandom_range(0, 6));
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    step();
    chk("bp_drained", 64'(out_valid32), 64'd0);
    step();

    // Flush with two entries held and a beat presented in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    instr = $urandom; imm_src = 3'($urandom_range(0, 7));
    step();
    instr = $urandom; imm_src = 3'($urandom_range(0, 7));
    step();
    flush = 1'b1; instr = $urandom; imm_src = 3'($urandom_range(0, 7));
    step();
    chk("flush_out_valid", 64'(out_valid32), 64'd0);
    chk("flush_in_ready",  64'(in_ready32),  64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    instr = $urandom; imm_src = 3'($urandom_range(0, 7));
    step();
    instr = $urandom; imm_src = 3'($urandom_range(0, 7));
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid32), 64'd0);
    chk("async_rst_imm32", 64'(imm32), 64'(RST32));
    chk("async_rst_imm64", imm64, RST64);
    chk("async_rst_ready", 64'(in_ready32), 64'd1);
    q.delete();
    e32 = RST32;
    e64 = RST64;
    step();
    rst = 1'b0;
    instr = $urandom; imm_src = 3'($urandom_range(0, 7));
    step();
    chk("post_rst_accept", 64'(out_valid32), 64'd1);
    in_valid = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      step();
    end

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
